// File: rtl/exce_capture_pkg.sv
// Shared definitions for the trap-cause capture stage: RISC-V exception
// cause codes, the capture FSM states and the priority-ordered flag vector.
package exce_capture_pkg;

   // RISC-V synchronous exception codes (mcause with interrupt bit clear)
   typedef enum logic [3:0] {
      EXC_IAM = 4'd0,
      EXC_IAF = 4'd1,
      EXC_LAM = 4'd4,
      EXC_LAF = 4'd5,
      EXC_SAM = 4'd6,
      EXC_SAF = 4'd7,
      EXC_IPF = 4'd12,
      EXC_LPF = 4'd13,
      EXC_SPF = 4'd15
   } exc_code_e;

   // Capture FSM: IDLE waits for a flag, HOLD keeps code/mtval until acknowledged
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Exception flags laid out in priority order, highest priority in the MSB
   typedef struct packed {
      logic ipf;   // instruction page fault
      logic iaf;   // instruction access fault
      logic iam;   // instruction address misaligned
      logic sam;   // store address misaligned
      logic lam;   // load address misaligned
      logic spf;   // store page fault
      logic lpf;   // load page fault
      logic saf;   // store access fault
      logic laf;   // load access fault
   } exc_flags_t;

endpackage

// File: rtl/exce_prio_enc.sv
// Combinational priority encoder: nine exception flags -> {hit, cause code}.
// Kept standalone so the interrupt path can reuse it.
module exce_prio_enc
   import exce_capture_pkg::*;
(
   input  exc_flags_t flags,
   output logic       hit,
   output exc_code_e  code
);

   // Pick the highest-priority asserted flag; code is a don't-care when hit=0
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
      hit  = |flags;
      code = EXC_IAM;
      if      (flags.ipf) code = EXC_IPF;
      else if (flags.iaf) code = EXC_IAF;
      else if (flags.iam) code = EXC_IAM;
      else if (flags.sam) code = EXC_SAM;
      else if (flags.lam) code = EXC_LAM;
      else if (flags.spf) code = EXC_SPF;
      else if (flags.lpf) code = EXC_LPF;
      else if (flags.saf) code = EXC_SAF;
      else if (flags.laf) code = EXC_LAF;
   end

endmodule

// File: rtl/exce_capture.sv
// Trap-cause capture stage. Priority-encodes the BIU exception flags into an
// mcause code, latches the faulting address as mtval and holds both until the
// trap-entry logic acknowledges them. A flush discards the held exception.
// Optional build macro EXCE_CNT_EN adds a saturating captured-exception counter.
module exce_capture
   import exce_capture_pkg::*;
#(
   parameter int AW = 32
`ifdef EXCE_CNT_EN
   ,
   parameter int CNT_W = 16
`endif
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          ins_addr_mis,
   input  logic          ins_acc_fault,
   input  logic          load_addr_mis,
   input  logic          load_acc_fault,
   input  logic          st_addr_mis,
   input  logic          st_acc_fault,
   input  logic          ins_page_fault,
   input  logic          ld_page_fault,
   input  logic          st_page_fault,
   input  logic [AW-1:0] fault_addr,
   input  logic          exc_ack,
   input  logic          exc_flush,
   output logic          exc_valid,
   output logic [3:0]    mcause_code,
   output logic [AW-1:0] mtval,
   output logic          exc_lost
`ifdef EXCE_CNT_EN
   ,
   output logic [CNT_W-1:0] exce_cnt
`endif
);

   exc_flags_t    flags;
   logic          any_exc;
   exc_code_e     win_code;
   logic          capture;

   state_e        state_q, state_d;
   exc_code_e     code_q;
   logic [AW-1:0] mtval_q;
   logic          lost_q, lost_d;

   assign flags = {ins_page_fault, ins_acc_fault, ins_addr_mis, st_addr_mis,
                   load_addr_mis, st_page_fault, ld_page_fault, st_acc_fault,
                   load_acc_fault};

   exce_prio_enc u_prio_enc (
      .flags (flags),
      .hit   (any_exc),
      .code  (win_code)
   );

   // A new exception is taken when idle, or back-to-back when the held one is acknowledged
   assign capture = any_exc && !exc_flush && ((state_q == ST_IDLE) || exc_ack);

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         state_q <= ST_IDLE;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lost_q  <= lost_d;
      end
   end

   // Next-state and sticky lost flag; flush overrides acknowledge and flags
   always_comb begin
      state_d = state_q;
      lost_d  = lost_q;
      if (exc_flush) begin
         state_d = ST_IDLE;
         lost_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (any_exc) state_d = ST_HOLD;
               lost_d = 1'b0;
            end
            ST_HOLD: begin
               if (exc_ack) begin
                  lost_d = 1'b0;
                  if (!any_exc) state_d = ST_IDLE;
               end else if (any_exc) begin
                  lost_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Captured cause code and fault address, frozen outside a capture
   always_ff @(posedge clk) begin
      // NOTE: these data registers are reset because the cleared code/mtval are visible after reset, not just don't-care.
      if (!rst) begin
         code_q  <= EXC_IAM;
         mtval_q <= '0;
      end else if (capture) begin
         code_q  <= win_code;
         mtval_q <= fault_addr;
      end
   end

   // Outputs are straight decodes of the registered state
   always_comb begin
      exc_valid   = (state_q == ST_HOLD);
      mcause_code = code_q;
      mtval       = mtval_q;
      exc_lost    = lost_q;
   end

`ifdef EXCE_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Saturating count of captures; survives flushes, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (capture && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign exce_cnt = cnt_q;
`else
   // Counter not built: capture only steers the code/mtval registers.
`endif

endmodule

// File: tb/tb_exce_capture.sv
// Self-checking bench for exce_capture: directed cases followed by random
// stimulus; a reference model pushes the expected outputs of every cycle into a
// scoreboard queue that an independent monitor drains and compares.
// Honours EXCE_CNT_EN when the design is built with it.
module tb_exce_capture;

   localparam int AW    = 32;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic          clk;
   logic          rst;
   logic [8:0]    flg;   // 0 iam,1 iaf,2 lam,3 laf,4 sam,5 saf,6 ipf,7 lpf,8 spf
   logic [AW-1:0] fault_addr;
   logic          exc_ack;
   logic          exc_flush;
   logic          exc_valid;
   logic [3:0]    mcause_code;
   logic [AW-1:0] mtval;
   logic          exc_lost;
`ifdef EXCE_CNT_EN
   logic [CNT_W-1:0] exce_cnt;
`endif

`ifdef EXCE_CNT_EN
   exce_capture #(.AW(AW), .CNT_W(CNT_W)) dut (
`else
   exce_capture #(.AW(AW)) dut (
`endif
      .clk            (clk),
      .rst            (rst),
      .ins_addr_mis   (flg[0]),
      .ins_acc_fault  (flg[1]),
      .load_addr_mis  (flg[2]),
      .load_acc_fault (flg[3]),
      .st_addr_mis    (flg[4]),
      .st_acc_fault   (flg[5]),
      .ins_page_fault (flg[6]),
      .ld_page_fault  (flg[7]),
      .st_page_fault  (flg[8]),
      .fault_addr     (fault_addr),
      .exc_ack        (exc_ack),
      .exc_flush      (exc_flush),
      .exc_valid      (exc_valid),
      .mcause_code    (mcause_code),
      .mtval          (mtval),
      .exc_lost       (exc_lost)
`ifdef EXCE_CNT_EN
      ,
      .exce_cnt       (exce_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected DUT outputs after one clock edge
   typedef struct {
      bit          valid;
      logic [3:0]  code;
      logic [31:0] tval;
      bit          lost;
      int          cnt;
      bit          chk_data;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   // Reference model state
   bit          m_valid;
   logic [3:0]  m_code;
   logic [31:0] m_tval;
   bit          m_lost;
   int          m_cnt;

   // Priority table, highest first: flag bit index and its cause code
   int prio_bit  [9] = '{6, 1, 0, 4, 2, 8, 7, 5, 3};
   int prio_code [9] = '{12, 1, 0, 6, 4, 15, 13, 7, 5};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // One clock of stimulus: drive inputs, advance the model, queue the expectation
   task automatic cycle(input bit r, input logic [8:0] f, input logic [31:0] a,
                        input bit ack, input bit fl);
      exp_t e;
      int   win;
      rst = r; flg = f; fault_addr = a; exc_ack = ack; exc_flush = fl;
      win = -1;
      for (int i = 0; i < 9; i++)
         if (win < 0 && f[prio_bit[i]]) win = prio_code[i];
      if (!r) begin
         m_valid = 0; m_code = 4'd0; m_tval = '0; m_lost = 0; m_cnt = 0;
      end else if (fl) begin
         m_valid = 0; m_lost = 0;
      end else if (!m_valid || ack) begin
         m_lost = 0;
         if (win >= 0) begin
            m_valid = 1; m_code = 4'(win); m_tval = a;
            if (m_cnt < CMAX) m_cnt++;
         end else begin
            m_valid = 0;
         end
      end else if (win >= 0) begin
         m_lost = 1;
      end
      e.valid = m_valid; e.code = m_code; e.tval = m_tval; e.lost = m_lost;
      e.cnt = m_cnt; e.chk_data = m_valid || !r;
      exp_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1, 9'h0, $urandom, 0, 0);
   endtask

   // Monitor: after each edge compare the DUT against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("exc_valid", 32'(exc_valid), 32'(e.valid));
            check("exc_lost", 32'(exc_lost), 32'(e.lost));
            if (e.chk_data) begin
               check("mcause_code", 32'(mcause_code), 32'(e.code));
               check("mtval", mtval, e.tval);
            end
`ifdef EXCE_CNT_EN
            check("exce_cnt", 32'(exce_cnt), 32'(e.cnt));
`endif
         end
      end
   end

   // Stimulus
   initial begin
      logic [8:0] f;
      int         wait_cyc;
      rst = 1'b0; flg = '0; fault_addr = '0; exc_ack = 0; exc_flush = 0;

      // Reset held for three clocks
      for (int i = 0; i < 3; i++) cycle(0, 9'h0, 32'h0, 0, 0);
      idle(1);

      // Single-cycle load page fault, held until acknowledged
      cycle(1, 9'h080, 32'h8000_1004, 0, 0);
      idle(2);
      cycle(1, 9'h0, 32'h0, 1, 0);
      idle(1);

      // Instruction access fault beats load access fault in the same cycle
      cycle(1, 9'h00A, 32'h0000_0FFC, 0, 0);
      cycle(1, 9'h0, 32'h0, 1, 0);

      // Store access fault held; later store page fault only sets exc_lost
      cycle(1, 9'h020, 32'h1234_5678, 0, 0);
      cycle(1, 9'h100, 32'hDEAD_BEEF, 0, 0);
      idle(1);
      cycle(1, 9'h0, 32'h0, 1, 0);
      idle(1);

      // Acknowledge coincident with a new store misalign: back-to-back capture
      cycle(1, 9'h008, 32'h4000_0000, 0, 0);
      cycle(1, 9'h010, 32'h2000_0002, 1, 0);
      idle(1);
      cycle(1, 9'h0, 32'h0, 1, 0);

      // Flush with acknowledge and a new flag discards everything
      cycle(1, 9'h040, 32'h5000_0000, 0, 0);
      cycle(1, 9'h001, 32'h6000_0000, 1, 1);
      idle(1);

      // Acknowledge while idle is ignored; reset in the middle of a hold
      cycle(1, 9'h0, 32'h0, 1, 0);
      cycle(1, 9'h004, 32'h7000_0010, 0, 0);
      cycle(0, 9'h004, 32'h7000_0020, 0, 0);
      idle(1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 7))
            0, 1, 2: f = 9'h1 << $urandom_range(0, 8);
            3:       f = 9'($urandom);
            default: f = 9'h0;
         endcase
         cycle(($urandom_range(0, 199) != 0), f, $urandom,
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
      end
      idle(2);

      // Bounded drain of the scoreboard
      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      #3;
      if (exp_q.size() > 0) begin
         n_miss++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
